// File: rtl/width_down_fifo.sv
// width_down_fifo: accepts wide beats of MULER words and emits them one
// word per cycle, word 0 first, through a registered output stage.
//
// Parameters
//   DATA_WIDTH  width of one output word
//   MULER       words per input beat (power of two, >= 2)
//   DEPTH       capacity in words (power of two, multiple of MULER);
//               storage is ENTRIES = DEPTH/MULER wide entries
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            synchronous discard of stored and output-stage data
//   in_valid/ready   wide beat handshake, in_data = {word[MULER-1]..word[0]}
//   out_valid/ready  narrow word handshake, out_data registered
//   count            occupied wide entries (only with WDFIFO_COUNT_EN)
//
// Build option: define WDFIFO_COUNT_EN to expose the count port.
module width_down_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int MULER      = 4,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MULER*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data
`ifdef WDFIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH/MULER+1)-1:0] count
`endif
);

  localparam int ENTRIES = DEPTH / MULER;
  localparam int PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int IW      = $clog2(MULER);
  localparam int CW      = $clog2(ENTRIES + 1);

  // Wide entry viewed as a packed array of narrow words.
  logic [MULER-1:0][DATA_WIDTH-1:0] in_words;
  logic [MULER-1:0][DATA_WIDTH-1:0] mem [ENTRIES];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic [CW-1:0] occ;

  logic wr_en, load, pop, last_word;

  for (genvar k = 0; k < MULER; k++) begin : g_split
    assign in_words[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // in_ready looks only at registered occupancy, so a pop this cycle does
  // not open the input until the next one.
  assign in_ready  = (occ < CW'(ENTRIES));
  assign wr_en     = in_valid & in_ready & ~flush;
  assign load      = (~out_valid | out_ready) & (occ != '0) & ~flush;
  assign last_word = (idx == IW'(MULER - 1));
  assign pop       = load & last_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is never reset; reads only ever target written entries.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= in_words;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      occ       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);

      if (load) begin
        out_data  <= mem[rd_ptr][idx];
        out_valid <= 1'b1;
        idx       <= last_word ? '0 : idx + 1'b1;
        if (last_word) rd_ptr <= ptr_inc(rd_ptr);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Write and pop together leave occupancy unchanged.
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef WDFIFO_COUNT_EN
  assign count = occ;
`endif

endmodule

// File: tb/tb_width_down_fifo.sv
// Scoreboard bench for width_down_fifo (DATA_WIDTH=32, MULER=4, DEPTH=16).
// Accepted beats push their four words into exp_q; a negedge monitor pops
// and compares on every output handshake.
module tb_width_down_fifo;
  localparam int DW = 32;
  localparam int M  = 4;
  localparam int D  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [M*DW-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
`ifdef WDFIFO_COUNT_EN
  logic [2:0]     count;
`endif

  width_down_fifo #(.DATA_WIDTH(DW), .MULER(M), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef WDFIFO_COUNT_EN
    , .count(count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  bit rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output word must be the next expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [M*DW-1:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push_beat(input logic [M*DW-1:0] d);
    for (int k = 0; k < M; k++) exp_q.push_back(d[k*DW +: DW]);
  endtask

  task automatic chk_count(input string nm, input int exp);
`ifdef WDFIFO_COUNT_EN
    chk(nm, 32'(count), 32'(exp));
`else
    chk(nm, 32'(in_ready), 32'(exp < 4));
`endif
  endtask

  task automatic send_beat(input logic [M*DW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        push_beat(d);
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      else tick();
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [M*DW-1:0] b4;
  bit acc;

  initial begin
    // Reset
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_count("rst_count", 0);

    // Single beat, latency and back-to-back words
    out_ready = 1'b1;
    in_data   = mk(32'h11, 32'h22, 32'h33, 32'h44);
    in_valid  = 1'b1;
    chk("a_in_ready", 32'(in_ready), 1);
    push_beat(in_data);
    tick();
    in_valid = 1'b0;
    chk("a_lat_t1", 32'(out_valid), 0);
    tick();
    chk("a_lat_t2", 32'(out_valid), 1);
    chk("a_word0", out_data, 32'h11);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("a_stream_valid", 32'(out_valid), 1);
    end
    tick();
    chk("a_drained", 32'(out_valid), 0);
    chk("a_q_empty", 32'(exp_q.size()), 0);

    // Fill to full with the consumer stalled
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_data  = mk(32'h100 + 32'(b*16), 32'h101 + 32'(b*16),
                    32'h102 + 32'(b*16), 32'h103 + 32'(b*16));
      in_valid = 1'b1;
      chk("b_in_ready", 32'(in_ready), 1);
      push_beat(in_data);
      tick();
    end
    b4 = mk(32'h200, 32'h201, 32'h202, 32'h203);
    in_data = b4;
    chk("b_full_in_ready", 32'(in_ready), 0);
    chk_count("b_count", 4);
    chk("b_hold_valid", 32'(out_valid), 1);
    chk("b_hold_data", out_data, 32'h100);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("b_still_full", 32'(in_ready), 0);
      chk("b_stable_data", out_data, 32'h100);
    end

    // Release: stream 16 words, the pending beat enters after first pop
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c <= 3) chk("c_in_ready", 32'(in_ready), 32'(c == 3));
      if (in_valid && in_ready) begin
        push_beat(b4);
        acc = 1'b1;
      end
      chk("c_no_gap", 32'(out_valid), 32'(c < 20));
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("c_q_empty", 32'(exp_q.size()), 0);

    // Wrap-around with random backpressure: words 0..47
    rand_rdy = 1'b1;
    for (int b = 0; b < 12; b++)
      send_beat(mk(32'(4*b), 32'(4*b+1), 32'(4*b+2), 32'(4*b+3)));
    drain("d_drain");
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

    // Flush with two entries stored and a same-cycle write
    out_ready = 1'b0;
    send_beat(mk(32'hE00, 32'hE01, 32'hE02, 32'hE03));
    send_beat(mk(32'hE10, 32'hE11, 32'hE12, 32'hE13));
    chk("e_pre_valid", 32'(out_valid), 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(32'hEF0, 32'hEF1, 32'hEF2, 32'hEF3);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("e_valid", 32'(out_valid), 0);
    chk_count("e_count", 0);
    chk("e_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e_stays_empty", 32'(out_valid), 0);
    end
    send_beat(mk(32'hE20, 32'hE21, 32'hE22, 32'hE23));
    drain("e_drain");

    // Reset mid-stream with a held word
    out_ready = 1'b0;
    send_beat(mk(32'hF00, 32'hF01, 32'hF02, 32'hF03));
    send_beat(mk(32'hF10, 32'hF11, 32'hF12, 32'hF13));
    tick();
    chk("f_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("f_valid", 32'(out_valid), 0);
    chk("f_data", out_data, 0);
    chk_count("f_count", 0);
    chk("f_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    in_data   = mk(32'hA, 32'hB, 32'hC, 32'hD);
    in_valid  = 1'b1;
    push_beat(in_data);
    tick();
    in_valid = 1'b0;
    tick();
    chk("f_first_word", out_data, 32'hA);
    drain("f_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
